// File: rtl/mux4_1_rr.sv
// ---------------------------------------------------------------------------
// mux4_1_rr
// Four-channel to one-channel multiplexer with a round-robin arbiter and a
// registered output stage. Sel tags every output word with its source
// channel so a downstream demultiplexer can route it back.
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   In1..In4    [W]     channel data
//   Valid1..Valid4      channel k holds a word on Ink
//   Ready1..Ready4      channel k word is accepted this cycle
//   Out         [W]     registered output data
//   Sel         [2]     source of Out (0 = In1 .. 3 = In4)
//   Out_valid           Out/Sel hold a word
//   Out_ready           downstream accepts the word
//   Count       [CNT_W] completed output handshakes, wraps
// ---------------------------------------------------------------------------
module mux4_1_rr #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     In1,
    input  logic [W-1:0]     In2,
    input  logic [W-1:0]     In3,
    input  logic [W-1:0]     In4,
    input  logic             Valid1,
    input  logic             Valid2,
    input  logic             Valid3,
    input  logic             Valid4,
    output logic             Ready1,
    output logic             Ready2,
    output logic             Ready3,
    output logic             Ready4,
    output logic [W-1:0]     Out,
    output logic [1:0]       Sel,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [CNT_W-1:0] Count
);

    logic [1:0]   last;
    logic [3:0]   valid_vec;
    logic         any_valid;
    logic         load_en;
    logic [1:0]   grant;
    logic [W-1:0] grant_data;

    assign valid_vec = {Valid4, Valid3, Valid2, Valid1};
    assign any_valid = |valid_vec;

    // rst_n is folded in so no Ready pulse can escape while the block is
    // held in reset (Out_valid is 0 then, which would otherwise allow a load).
    assign load_en = rst_n && (!Out_valid || Out_ready) && any_valid;

    // Search starts one past the last winner and wraps. Walking the offsets
    // from the far end toward the near end lets the closest requester win.
    always_comb begin
        grant = last + 2'd1;
        for (int i = 3; i >= 0; i--) begin
            if (valid_vec[last + 2'd1 + 2'(i)]) begin
                grant = last + 2'd1 + 2'(i);
            end
        end
    end

    always_comb begin
        grant_data = In1;
        case (grant)
            2'd0:    grant_data = In1;
            2'd1:    grant_data = In2;
            2'd2:    grant_data = In3;
            default: grant_data = In4;
        endcase
    end

    assign Ready1 = load_en && (grant == 2'd0);
    assign Ready2 = load_en && (grant == 2'd1);
    assign Ready3 = load_en && (grant == 2'd2);
    assign Ready4 = load_en && (grant == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out       <= '0;
            Sel       <= 2'd0;
            Out_valid <= 1'b0;
            Count     <= '0;
            last      <= 2'd3;
        end else begin
            // A load on the same edge as a consume keeps Out_valid high.
            if (load_en) begin
                Out       <= grant_data;
                Sel       <= grant;
                Out_valid <= 1'b1;
                last      <= grant;
            end else if (Out_valid && Out_ready) begin
                Out_valid <= 1'b0;
            end
            if (Out_valid && Out_ready) begin
                Count <= Count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux4_1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux4_1_rr
// Scoreboard bench for mux4_1_rr. A reference model grants channels by the
// round-robin rule and queues expected (data, sel) words; a monitor pops and
// compares whenever the DUT presents a word. A second instance with a 4-bit
// counter exercises Count wrap-around.
// ---------------------------------------------------------------------------
module tb_mux4_1_rr;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     din [4];
    logic [3:0]       vld;
    logic [3:0]       rdy;
    logic [3:0]       rdy4;
    logic [W-1:0]     out;
    logic [W-1:0]     out4;
    logic [1:0]       sel;
    logic [1:0]       sel4;
    logic             ov;
    logic             ov4;
    logic             oready;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cnt4;

    always #5 clk = ~clk;

    mux4_1_rr #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .In1(din[0]), .In2(din[1]), .In3(din[2]), .In4(din[3]),
        .Valid1(vld[0]), .Valid2(vld[1]), .Valid3(vld[2]), .Valid4(vld[3]),
        .Ready1(rdy[0]), .Ready2(rdy[1]), .Ready3(rdy[2]), .Ready4(rdy[3]),
        .Out(out), .Sel(sel), .Out_valid(ov), .Out_ready(oready), .Count(cnt)
    );

    mux4_1_rr #(.W(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .In1(din[0]), .In2(din[1]), .In3(din[2]), .In4(din[3]),
        .Valid1(vld[0]), .Valid2(vld[1]), .Valid3(vld[2]), .Valid4(vld[3]),
        .Ready1(rdy4[0]), .Ready2(rdy4[1]), .Ready3(rdy4[2]), .Ready4(rdy4[3]),
        .Out(out4), .Sel(sel4), .Out_valid(ov4), .Out_ready(oready), .Count(cnt4)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
    } word_t;

    word_t      sbq[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         m_last = 3;
    int         exp_count = 0;
    logic [3:0] hs_m = '0;
    bit         model_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented word against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && model_on) begin
            check("count", cnt, exp_count % 65536);
            check("count_w4", cnt4, exp_count % 16);
            check("out_valid", ov, sbq.size() != 0);
            check("out_valid_w4", ov4, sbq.size() != 0);
            if (sbq.size() != 0) begin
                check("out", out, sbq[0].d);
                check("sel", sel, sbq[0].s);
                if (oready) begin
                    void'(sbq.pop_front());
                    exp_count++;
                end
            end
        end
    end

    // Reference model: runs after the monitor so a consumed word frees the slot.
    always @(negedge clk) begin
        if (rst_n && model_on) begin : mdl
            int         g;
            logic [3:0] er;
            #1;
            g  = -1;
            er = '0;
            if (sbq.size() == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last + k) % 4;
                    if (g < 0 && vld[c]) g = c;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            check("ready", rdy, er);
            check("ready_w4", rdy4, er);
            hs_m = er;
            if (g >= 0) begin
                sbq.push_back(word_t'{din[g], g[1:0]});
                m_last = g;
            end
        end
    end

    task automatic release_reset();
        @(posedge clk); #1;
        sbq.delete();
        m_last    = 3;
        exp_count = 0;
        hs_m      = '0;
        rst_n     = 1'b1;
        model_on  = 1'b1;
    endtask

    // Random traffic; a channel only changes its word after a handshake.
    task automatic run_random(input int n, input int p_valid, input int p_ready);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            for (int c = 0; c < 4; c++) begin
                if (hs_m[c] || !vld[c]) begin
                    vld[c] = ($urandom_range(99) < p_valid);
                    din[c] = W'($urandom);
                end
            end
            oready = ($urandom_range(99) < p_ready);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        vld    = 4'hF;
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        oready = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state with all channels requesting.
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", rdy, 4'h0);
        check("rst_out", out, 8'h00);
        check("rst_sel", sel, 2'd0);
        check("rst_out_valid", ov, 1'b0);
        check("rst_count", cnt, 0);

        // Round robin: 8 grants with everyone requesting.
        release_reset();
        repeat (8) @(posedge clk);
        #1 vld = 4'h0;
        @(posedge clk); #1;
        check("rr_count", cnt, 8);

        // Backpressure on a single channel.
        oready = 1'b0;
        vld    = 4'b0100;
        din[2] = 8'hA5;
        @(posedge clk); #1;
        check("bp_out_valid", ov, 1'b1);
        check("bp_out", out, 8'hA5);
        check("bp_sel", sel, 2'd2);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_stable_out", out, 8'hA5);
            check("bp_ready3_low", rdy[2], 1'b0);
        end
        oready = 1'b1;
        #1 check("bp_ready3_release", rdy[2], 1'b1);
        @(posedge clk); #1;
        check("bp_count", cnt, 9);

        // Wrap-around priority: last winner is channel 4.
        vld    = 4'b1000;
        din[3] = 8'h44;
        @(posedge clk); #1;
        vld    = 4'b1010;
        din[1] = 8'h22;
        #1 check("wrap_first_grant", rdy, 4'b0010);
        @(posedge clk); #1;
        vld[1] = 1'b0;
        #1 check("wrap_second_grant", rdy, 4'b1000);
        @(posedge clk); #1;
        vld = 4'h0;

        // Drain a single word.
        vld    = 4'b0001;
        din[0] = 8'h5A;
        @(posedge clk); #1;
        vld = 4'h0;
        check("drain_loaded", out, 8'h5A);
        @(posedge clk); #1;
        check("drain_out_valid", ov, 1'b0);
        check("drain_out_hold", out, 8'h5A);

        run_random(600, 50, 70);
        run_random(600, 90, 40);
        run_random(300, 20, 100);
        run_random(12, 0, 100);

        // Reset mid-stream while a word is held.
        vld    = 4'b0001;
        din[0] = 8'h77;
        oready = 1'b0;
        @(posedge clk); #1;
        vld = 4'h0;
        #1;
        model_on = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", ov, 1'b0);
        check("midrst_ready", rdy, 4'h0);
        check("midrst_count", cnt, 0);
        check("midrst_out", out, 8'h00);

        // 17 transfers on the 4-bit counter instance.
        vld    = 4'hF;
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        oready = 1'b1;
        release_reset();
        repeat (17) @(posedge clk);
        #1 vld = 4'h0;
        @(posedge clk); #1;
        check("wrap_count_w4", cnt4, 4'd1);
        check("wrap_count_w16", cnt, 17);

        run_random(800, 60, 60);
        run_random(12, 0, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_1_rr.md
Name: mux4_1_rr

Overview:
- Four-channel to one-channel multiplexer with a round-robin arbiter and a registered output stage.
- Inverse of the DeMUX4_1 path: four 8-bit sources In1..In4 feed one output stream Out.
- Sel reports which channel each output word came from, so a downstream DeMUX4_1 can route it back by S.
- Valid/ready handshake on every input and on the output; sustained throughput is one word per cycle.

Parameters:
- W, 8, data width of In1..In4 and Out.
- CNT_W, 16, width of the transfer counter Count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- In1, In2, In3, In4  input  W each  channel 1..4 data.
- Valid1..Valid4  input  1 each  channel k has a word on Ink.
- Ready1..Ready4  output  1 each  channel k word is accepted this cycle.
- Out  output  W  registered output data.
- Sel  output  2  source of Out: 0=In1, 1=In2, 2=In3, 3=In4.
- Out_valid  output  1  Out/Sel hold a word.
- Out_ready  input  1  downstream accepts the word.
- Count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Out=0, Sel=0, Out_valid=0, Count=0.
  - Internal pointer Last=3, so channel 1 has first priority after reset.
  - Ready1..4 are 0 while rst_n is low.
- Load enable: load_en = (!Out_valid || Out_ready) && (Valid1|Valid2|Valid3|Valid4).
- Arbitration (combinational):
  - Search order starts at index (Last+1) mod 4 and wraps: Last=3 searches 0,1,2,3; Last=1 searches 2,3,0,1.
  - The first asserted Valid in that order wins, giving grant index g.
- Ready outputs:
  - Ready_k = load_en && (g == k-1), combinational.
  - At most one Ready is high per cycle.
  - Ready never depends on Ready of the same channel; it may depend on Out_ready.
- On a clock edge with load_en:
  - Out <= In(g+1), Sel <= g, Out_valid <= 1, Last <= g.
- On a clock edge with Out_valid && Out_ready && !load_en: Out_valid <= 0. Out and Sel keep their last values.
- In all other cases, Out, Sel and Out_valid hold. While Out_valid && !Out_ready, Out and Sel must not change.
- Count:
  - Increments by 1 on each edge with Out_valid && Out_ready.
  - Wraps modulo 2^CNT_W, from all-ones to 0.
- Latency and throughput:
  - One cycle from the input handshake (Valid_k && Ready_k) to Out_valid.
  - Back-to-back loads happen when Out_ready is held high: the output word is replaced in the same cycle it is consumed.
- Input rules:
  - Once asserted, Valid_k and Ink stay stable until Ready_k.
  - A channel that is not granted sees Ready_k=0 and simply waits.
- Fairness: with all four Valid high and Out_ready high, grants go 0,1,2,3,0,... So each channel waits at most 3 grants.
- Simultaneous events: if the output is consumed and a new word is granted on the same edge, the load wins (Out_valid stays 1) and Count increments.
- Reset mid-operation: any held output word is discarded, no Ready pulse is generated, and the pointer returns to Last=3.
- Single asserted channel: that channel gets every grant, regardless of Last.

Test Plan:
- Reset: hold rst_n=0 with Valid1..4=1 and In1..In4=8'h11,8'h22,8'h33,8'h44 -> Ready1..4=0, Out=0, Sel=0, Out_valid=0, Count=0.
- Round robin: release reset with all Valid=1 and Out_ready=1 for 8 cycles -> Out sequence 11,22,33,44,11,22,33,44; Sel sequence 0,1,2,3,0,1,2,3; Count=8 afterwards.
- Backpressure: only Valid3=1, In3=8'hA5, Out_ready=0 -> Out_valid=1, Out=A5, Sel=2 after 1 cycle; Ready3=0 while stalled; Out stable for 5 cycles. Then Out_ready=1 -> Count+1 and Ready3 high again in the same cycle.
- Wrap-around priority: after the last grant was index 3, raise Valid2 and Valid4 together -> Sel=1 (In2) is granted first, then Sel=3.
- Drain: a single word from In1=8'h5A, then all Valid=0 with Out_ready=1 -> Out_valid drops 1 cycle after consumption, and Out stays 5A.
- Reset mid-stream and counter wrap:
  - Assert rst_n=0 while Out_valid=1 -> Out_valid=0 immediately (asynchronous).
  - Separately, with CNT_W=4, run 17 transfers -> Count=1.
